// File: rtl/vga_pkg.sv
// Shared VGA timing, framebuffer scaling and RGB332 layout constants.
package vga_pkg;

   localparam int H_VIS   = 640;
   localparam int H_FP    = 16;
   localparam int H_SYNC  = 96;
   localparam int H_BP    = 48;
   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

   localparam int V_VIS   = 480;
   localparam int V_FP    = 10;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 33;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam int SCALE_X = 10;
   localparam int SCALE_Y = 15;
   localparam int LOG_W   = 64;
   localparam int LOG_H   = 32;
   localparam int LX_W    = $clog2(LOG_W);
   localparam int LY_W    = $clog2(LOG_H);
   localparam int WORD_W  = LY_W + LX_W - 2;

   localparam int R_HI = 7;
   localparam int R_LO = 5;
   localparam int G_HI = 4;
   localparam int G_LO = 2;
   localparam int B_HI = 1;
   localparam int B_LO = 0;

   typedef struct packed {
      logic [9:0] hcount;
      logic [9:0] vcount;
      logic [1:0] lane;
      logic       hs_n;
      logic       vs_n;
      logic       active;
   } scan_t;

endpackage

// File: rtl/vga_timing.sv
// 640x480@60 raster counters on a half-rate pixel enable, plus the
// divider-free sub-counters that map screen pixels onto the 64x32 frame.
module vga_timing
   import vga_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              pix_en_o,
   output scan_t             scan_o,
   output logic [WORD_W-1:0] word_nxt_o
);

   logic            pix_en_q;
   logic [9:0]      hcount_q, hcount_d;
   logic [9:0]      vcount_q, vcount_d;
   logic [3:0]      hsub_q, hsub_d;
   logic [3:0]      vsub_q, vsub_d;
   logic [LX_W-1:0] lx_q, lx_d;
   logic [LY_W-1:0] ly_q, ly_d;
   logic            h_end, v_end, hsub_end, vsub_end;

   assign h_end    = hcount_q == 10'(H_TOTAL - 1);
   assign v_end    = vcount_q == 10'(V_TOTAL - 1);
   assign hsub_end = hsub_q == 4'(SCALE_X - 1);
   assign vsub_end = vsub_q == 4'(SCALE_Y - 1);

   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      hsub_d   = hsub_q;
      vsub_d   = vsub_q;
      lx_d     = lx_q;
      ly_d     = ly_q;
      if (pix_en_q) begin
         if (h_end) begin
            hcount_d = '0;
            hsub_d   = '0;
            lx_d     = '0;
            if (v_end) begin
               vcount_d = '0;
               vsub_d   = '0;
               ly_d     = '0;
            end else begin
               vcount_d = vcount_q + 10'd1;
               if (vsub_end) begin
                  vsub_d = '0;
                  ly_d   = ly_q + LY_W'(1);
               end else begin
                  vsub_d = vsub_q + 4'd1;
               end
            end
         end else begin
            hcount_d = hcount_q + 10'd1;
            // lx keeps running through blanking; only its visible values matter
            if (hsub_end) begin
               hsub_d = '0;
               lx_d   = lx_q + LX_W'(1);
            end else begin
               hsub_d = hsub_q + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pix_en_q <= 1'b0;
         hcount_q <= '0;
         vcount_q <= '0;
         hsub_q   <= '0;
         vsub_q   <= '0;
         lx_q     <= '0;
         ly_q     <= '0;
      end else begin
         pix_en_q <= ~pix_en_q;
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         hsub_q   <= hsub_d;
         vsub_q   <= vsub_d;
         lx_q     <= lx_d;
         ly_q     <= ly_d;
      end
   end

   assign pix_en_o   = pix_en_q;
   // word index of the pixel being entered, so the address register leads data
   assign word_nxt_o = {ly_d, lx_d[LX_W-1:2]};

   always_comb begin
      scan_o        = '0;
      scan_o.hcount = hcount_q;
      scan_o.vcount = vcount_q;
      scan_o.lane   = lx_q[1:0];
      scan_o.hs_n   = !((hcount_q >= 10'(H_VIS + H_FP)) &&
                        (hcount_q <  10'(H_VIS + H_FP + H_SYNC)));
      scan_o.vs_n   = !((vcount_q >= 10'(V_VIS + V_FP)) &&
                        (vcount_q <  10'(V_VIS + V_FP + V_SYNC)));
      scan_o.active = (hcount_q < 10'(H_VIS)) && (vcount_q < 10'(V_VIS));
   end

endmodule

// File: rtl/vga_fb_reader.sv
// Framebuffer scan-out: drives the dmem VGA read port and turns the returned
// RGB332 words into VGA sync, blank and colour, one pixel behind the counters.
module vga_fb_reader
   import vga_pkg::*;
#(
   parameter int VGA_BITS = 8,
   parameter int ADDR_W   = 9,
   parameter int FB_BASE  = 0
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic [31:0]         read_data_vga,
   output logic [31:0]         addr_vga,
   output logic [VGA_BITS-1:0] VGA_R,
   output logic [VGA_BITS-1:0] VGA_G,
   output logic [VGA_BITS-1:0] VGA_B,
   output logic                VGA_HS_O,
   output logic                VGA_VS_O,
   output logic                VGA_BLANK_N,
   output logic                VGA_CLK_O,
   output logic                frame_start
);

   localparam logic [31:0] ADDR_MASK  = (32'd1 << ADDR_W) - 32'd1;
   localparam logic [31:0] ADDR_RESET = 32'(FB_BASE) & ADDR_MASK;

   logic              pix_en;
   scan_t             scan;
   logic [WORD_W-1:0] word_nxt;

   vga_timing u_timing (
      .clk_i      (CLOCK_50),
      .rst_i      (reset),
      .pix_en_o   (pix_en),
      .scan_o     (scan),
      .word_nxt_o (word_nxt)
   );

   logic [31:0]         addr_q, addr_d;
   logic [7:0]          pix_byte;
   logic [2:0]          r3, g3;
   logic [1:0]          b2;
   logic [VGA_BITS-1:0] r_exp, g_exp, b_exp;
   logic [VGA_BITS-1:0] r_q, g_q, b_q;
   logic                hs_q, vs_q, blank_n_q, vga_clk_q, frame_start_q;

   always_comb begin
      addr_d   = (32'(FB_BASE) + 32'(word_nxt)) & ADDR_MASK;
      pix_byte = read_data_vga[{scan.lane, 3'b000} +: 8];
      r3       = pix_byte[R_HI:R_LO];
      g3       = pix_byte[G_HI:G_LO];
      b2       = pix_byte[B_HI:B_LO];
      r_exp    = '0;
      g_exp    = '0;
      b_exp    = '0;
      // repeat the field MSB-first so full-scale codes map to all ones
      for (int i = 0; i < VGA_BITS; i++) begin
         r_exp[VGA_BITS-1-i] = r3[2 - (i % 3)];
         g_exp[VGA_BITS-1-i] = g3[2 - (i % 3)];
         b_exp[VGA_BITS-1-i] = b2[1 - (i % 2)];
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         addr_q        <= ADDR_RESET;
         r_q           <= '0;
         g_q           <= '0;
         b_q           <= '0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         blank_n_q     <= 1'b0;
         vga_clk_q     <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         vga_clk_q     <= pix_en;
         frame_start_q <= pix_en && (scan.hcount == 10'(H_TOTAL - 1)) &&
                          (scan.vcount == 10'(V_VIS - 1));
         if (pix_en) begin
            addr_q    <= addr_d;
            r_q       <= scan.active ? r_exp : '0;
            g_q       <= scan.active ? g_exp : '0;
            b_q       <= scan.active ? b_exp : '0;
            hs_q      <= scan.hs_n;
            vs_q      <= scan.vs_n;
            blank_n_q <= scan.active;
         end
      end
   end

   assign addr_vga    = addr_q;
   assign VGA_R       = r_q;
   assign VGA_G       = g_q;
   assign VGA_B       = b_q;
   assign VGA_HS_O    = hs_q;
   assign VGA_VS_O    = vs_q;
   assign VGA_BLANK_N = blank_n_q;
   assign VGA_CLK_O   = vga_clk_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Self-checking bench: arithmetic raster model of the scan-out checked every
// clock, a directed pixel-decode table and a few timing measurements.
module tb_vga_fb_reader;

   localparam int unsigned FRAME   = 800 * 525;
   localparam int unsigned FB_BASE = 0;

   logic        clk;
   logic        rst;
   logic [31:0] rdata;
   logic [31:0] addr_vga;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   logic        VGA_HS_O, VGA_VS_O, VGA_BLANK_N, VGA_CLK_O, frame_start;

   vga_fb_reader #(.VGA_BITS(8), .ADDR_W(9), .FB_BASE(0)) dut (
      .CLOCK_50      (clk),
      .reset         (rst),
      .read_data_vga (rdata),
      .addr_vga      (addr_vga),
      .VGA_R         (VGA_R),
      .VGA_G         (VGA_G),
      .VGA_B         (VGA_B),
      .VGA_HS_O      (VGA_HS_O),
      .VGA_VS_O      (VGA_VS_O),
      .VGA_BLANK_N   (VGA_BLANK_N),
      .VGA_CLK_O     (VGA_CLK_O),
      .frame_start   (frame_start)
   );

   typedef struct packed {
      logic [7:0]  r, g, b;
      logic        hs, vs, bl, vc, fs;
      logic [31:0] addr;
   } obs_t;

   typedef struct {
      int         lx;
      logic [7:0] r, g, b;
   } vec_t;

   logic [31:0] mem [512];
   int unsigned n_edge;
   int          total, bad;
   bit          chk_en;
   vec_t        vec [8];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // edges since the last clock that sampled reset high
   initial begin
      n_edge = 0;
      forever begin
         @(posedge clk);
         n_edge = rst ? 0 : n_edge + 1;
      end
   end

   // memory answers within the clock after the address edge
   initial begin
      rdata = '0;
      forever begin
         @(posedge clk);
         #1 rdata = mem[addr_vga[8:0]];
      end
   end

   function automatic logic [7:0] ex3(input logic [2:0] x);
      return {x, x, x[2:1]};
   endfunction

   function automatic logic [7:0] ex2(input logic [1:0] x);
      return {x, x, x, x};
   endfunction

   function automatic logic [31:0] addr_of(input int unsigned p);
      int unsigned h, v;
      h = p % 800;
      v = p / 800;
      return 32'((FB_BASE + ((v / 15) % 32) * 16 + ((h / 10) % 64) / 4) % 512);
   endfunction

   function automatic obs_t model(input int unsigned n);
      obs_t        o;
      int unsigned u, p, q, h, v;
      logic [7:0]  by;
      o      = '0;
      o.hs   = 1'b1;
      o.vs   = 1'b1;
      o.addr = 32'(FB_BASE);
      if (n == 0) return o;
      u      = n / 2;
      p      = u % FRAME;
      o.addr = addr_of(p);
      o.vc   = ((n - 1) % 2) == 1;
      o.fs   = (n % 2 == 0) && (p == 480 * 800);
      if (u == 0) return o;
      q    = (p + FRAME - 1) % FRAME;
      h    = q % 800;
      v    = q / 800;
      o.hs = !(h >= 656 && h < 752);
      o.vs = !(v >= 490 && v < 492);
      if (h < 640 && v < 480) begin
         by   = 8'(mem[addr_of(q)] >> (8 * ((h / 10) % 4)));
         o.bl = 1'b1;
         o.r  = ex3(by[7:5]);
         o.g  = ex3(by[4:2]);
         o.b  = ex2(by[1:0]);
      end
      return o;
   endfunction

   function automatic obs_t sample();
      return obs_t'({VGA_R, VGA_G, VGA_B, VGA_HS_O, VGA_VS_O, VGA_BLANK_N,
                     VGA_CLK_O, frame_start, addr_vga});
   endfunction

   task automatic chk_obs(input string nm, input obs_t want);
      obs_t got;
      got = sample();
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s n=%0d got=%h want=%h", nm, n_edge, got, want);
      end
   endtask

   task automatic chk_int(input string nm, input longint got, input longint want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   task automatic wait_n(input int unsigned t);
      int g;
      g = 0;
      while (n_edge < t && g < 100000) begin
         @(negedge clk);
         g++;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) chk_obs("scan", model(n_edge));
      end
   end

   initial begin
      obs_t        rst_obs;
      int unsigned t0, blank_cnt, leak;
      int          g;
      logic [31:0] a0;

      total  = 0;
      bad    = 0;
      chk_en = 1'b0;
      rst    = 1'b1;
      for (int i = 0; i < 512; i++) mem[i] = $urandom;
      mem[0] = 32'hE01C03FF;
      mem[1] = 32'h006D4992;

      vec[0] = '{0, 8'hFF, 8'hFF, 8'hFF};
      vec[1] = '{1, 8'h00, 8'h00, 8'hFF};
      vec[2] = '{2, 8'h00, 8'hFF, 8'h00};
      vec[3] = '{3, 8'hFF, 8'h00, 8'h00};
      vec[4] = '{4, 8'h92, 8'h92, 8'hAA};
      vec[5] = '{5, 8'h49, 8'h49, 8'h55};
      vec[6] = '{6, 8'h6D, 8'h6D, 8'h55};
      vec[7] = '{7, 8'h00, 8'h00, 8'h00};

      rst_obs    = '0;
      rst_obs.hs = 1'b1;
      rst_obs.vs = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk_obs("reset_state", rst_obs);
      rst = 1'b0;

      for (int k = 0; k < 8; k++) begin
         wait_n(20 * vec[k].lx + 10);
         total++;
         if ({VGA_R, VGA_G, VGA_B} !== {vec[k].r, vec[k].g, vec[k].b}) begin
            bad++;
            $display("FAIL pixel lx=%0d got=%h_%h_%h want=%h_%h_%h", vec[k].lx,
                     VGA_R, VGA_G, VGA_B, vec[k].r, vec[k].g, vec[k].b);
         end
      end

      g = 0;
      while (VGA_HS_O !== 1'b0 && g < 4000) begin @(negedge clk); g++; end
      chk_int("hs_first_fall", n_edge, 2 * 656 + 2);
      t0 = n_edge;
      g  = 0;
      while (VGA_HS_O !== 1'b1 && g < 4000) begin @(negedge clk); g++; end
      chk_int("hs_low_width", n_edge - t0, 192);
      g = 0;
      while (VGA_HS_O !== 1'b0 && g < 4000) begin @(negedge clk); g++; end
      chk_int("hs_period", n_edge - t0, 1600);

      g = 0;
      while (addr_vga !== 32'd16 && g < 30000) begin @(negedge clk); g++; end
      chk_int("line15_addr16_at", n_edge, 24000);
      t0 = n_edge;
      a0 = addr_vga;
      g  = 0;
      while (addr_vga === a0 && g < 1000) begin @(negedge clk); g++; end
      chk_int("addr_hold", n_edge - t0, 80);
      chk_int("addr_next", addr_vga, 17);

      wait_n(26000 + $urandom_range(0, 1999));
      rst = 1'b1;
      for (int i = 0; i < 512; i++) mem[i] = 32'hFFFF_FFFF;
      @(negedge clk);
      chk_obs("midframe_reset", rst_obs);
      rst = 1'b0;

      blank_cnt = 0;
      leak      = 0;
      while (n_edge < 4802) begin
         @(negedge clk);
         if (n_edge >= 2 && n_edge < 4802 && !VGA_BLANK_N) begin
            blank_cnt++;
            if ((VGA_R | VGA_G | VGA_B) != 8'h00) leak++;
         end
      end
      chk_int("blank_clocks", blank_cnt, 960);
      chk_int("rgb_in_blank", leak, 0);

      wait_n(6000);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
